multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 42 ++++
 rtl/multicycle_ctrl_aludec.sv | 20 ++
 rtl/multicycle_ctrl.sv | 140 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode/funct field values and ALU operation codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEXEC,
    S_ADDIWB,
    S_JUMP,
    S_IMMEXEC
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// R-type funct decoder: maps the funct field to an ALU operation code.
module aludec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default:   alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Build option: MULTICYCLE_IMM_LOGIC_EN adds andi/ori through IMMEXEC.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  state_t     r_state;
  state_t     w_state;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic [2:0] w_funct_alu;

  aludec u_aludec (
    .funct      (funct),
    .alucontrol (w_funct_alu)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            OP_J:         r_state <= S_JUMP;
`ifdef MULTICYCLE_IMM_LOGIC_EN
            OP_ANDI, OP_ORI: r_state <= S_IMMEXEC;
`endif
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    r_state <= S_MEMWB;
        S_EXECUTE:  r_state <= S_ALUWB;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        S_IMMEXEC:  r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs show the FETCH decode with all strobes off.
  always_comb begin
    w_state    = reset ? S_FETCH : r_state;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_AND;
    case (w_state)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        w_irwrite  = 1'b1;
        w_pcwrite  = 1'b1;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = w_funct_alu;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        w_branch   = 1'b1;
      end
      S_ADDIWB: w_regwrite = 1'b1;
      S_JUMP: begin
        pcsrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      S_IMMEXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = (op == OP_ORI) ? ALU_OR : ALU_AND;
      end
      default: ;
    endcase
  end

  assign pcen     = (w_pcwrite | (w_branch & zero)) & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign memwrite = w_memwrite & ~reset;
  assign regwrite = w_regwrite & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized instruction-stream bench for multicycle_ctrl with a per-instruction
// expected-control-word model; honours MULTICYCLE_IMM_LOGIC_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol)
  );

  always #5 clk = ~clk;

  // Word layout: {pcen,irwrite,memwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol}
  logic [14:0] dut_word;
  assign dut_word = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                     alusrcb, pcsrc, alucontrol};

  int n_checks = 0;
  int n_pass   = 0;

  logic [14:0] plan_q[$];
  logic [14:0] got[8];
  int          got_len;
  logic        zv[8];

  task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b want %b", nm, act, exp);
  endtask

  function automatic logic [14:0] cw(input logic pc, input logic irw, input logic mw,
                                     input logic rw, input logic io, input logic m2r,
                                     input logic rd, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu);
    return {pc, irw, mw, rw, io, m2r, rd, asa, asb, pcs, alu};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected control words for every cycle of one instruction.
  task automatic build_plan(input logic [5:0] o, input logic [5:0] f);
    plan_q.delete();
    plan_q.push_back(cw(1,1,0,0,0,0,0,0,2'b01,2'b00,3'b010));
    plan_q.push_back(cw(0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010));
    case (o)
      6'b100011: begin
        plan_q.push_back(cw(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
        plan_q.push_back(cw(0,0,0,0,1,0,0,0,2'b00,2'b00,3'b000));
        plan_q.push_back(cw(0,0,0,1,0,1,0,0,2'b00,2'b00,3'b000));
      end
      6'b101011: begin
        plan_q.push_back(cw(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
        plan_q.push_back(cw(0,0,1,0,1,0,0,0,2'b00,2'b00,3'b000));
      end
      6'b000000: begin
        plan_q.push_back(cw(0,0,0,0,0,0,0,1,2'b00,2'b00,funct_alu(f)));
        plan_q.push_back(cw(0,0,0,1,0,0,1,0,2'b00,2'b00,3'b000));
      end
      6'b000100: plan_q.push_back(cw(zv[2],0,0,0,0,0,0,1,2'b00,2'b01,3'b110));
      6'b001000: begin
        plan_q.push_back(cw(0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010));
        plan_q.push_back(cw(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000));
      end
      6'b000010: plan_q.push_back(cw(1,0,0,0,0,0,0,0,2'b00,2'b10,3'b000));
`ifdef MULTICYCLE_IMM_LOGIC_EN
      6'b001100, 6'b001101: begin
        plan_q.push_back(cw(0,0,0,0,0,0,0,1,2'b10,2'b00, (o == 6'b001101) ? 3'b001 : 3'b000));
        plan_q.push_back(cw(0,0,0,1,0,0,0,0,2'b00,2'b00,3'b000));
      end
`endif
      default: ;
    endcase
  endtask

  // Runs one instruction; zmode<0 randomizes zero; abort_at>=0 asserts reset on that cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int abort_at, input string nm);
    for (int k = 0; k < 8; k++) zv[k] = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    build_plan(o, f);
    got_len = 0;
    for (int k = 0; k < plan_q.size(); k++) begin
      @(negedge clk);
      op = o; funct = f; zero = zv[k];
      reset = (k == abort_at);
      #1;
      got[k] = dut_word;
      got_len = k + 1;
      if (k == abort_at) begin
        check($sformatf("%s_rst_c%0d", nm, k), dut_word, cw(0,0,0,0,0,0,0,0,2'b01,2'b00,3'b010));
        $display("instr %s op=%b funct=%b aborted by reset at cycle %0d", nm, o, f, k);
        return;
      end
      check($sformatf("%s_c%0d", nm, k), dut_word, plan_q[k]);
    end
    $display("instr %s op=%b funct=%b cycles=%0d", nm, o, f, got_len);
  endtask

  function automatic logic [5:0] pick_op(input int sel);
    case (sel)
      0: return 6'b100011;
      1: return 6'b101011;
      2: return 6'b000000;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'b001100;
      7: return 6'b001101;
      8: return 6'b111111;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_funct(input int sel);
    case (sel)
      0: return 6'b100000;
      1: return 6'b100010;
      2: return 6'b100100;
      3: return 6'b100101;
      4: return 6'b101010;
      default: return 6'($urandom);
    endcase
  endfunction

  logic       seen_strobe;
  logic [5:0] ro, rf;

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
    // Two reset cycles: FETCH decode with all strobes forced off.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); reset = 1'b1; #1;
      check($sformatf("reset_c%0d", k), dut_word, 15'b000000000100010);
      $display("reset cycle %0d word=%b", k, dut_word);
    end

    run_instr(6'b100011, 6'd0, -1, -1, "lw");
    check("lw_c5_regwrite_memtoreg", {13'd0, got[4][11], got[4][9]}, 15'b11);
    check("lw_c4_no_regwrite", {14'd0, got[3][11]}, 15'b0);

    run_instr(6'b000000, 6'b101010, -1, -1, "slt");
    check("slt_exec_alu", {12'd0, got[2][2:0]}, 15'b111);
    check("slt_aluwb_rd_rw", {13'd0, got[3][11], got[3][8]}, 15'b11);

    run_instr(6'b000100, 6'd0, 1, -1, "beq_z1");
    check("beq_z1_pcen_pcsrc", {12'd0, got[2][14], got[2][4:3]}, 15'b101);
    run_instr(6'b000100, 6'd0, 0, -1, "beq_z0");
    check("beq_z0_pcen", {14'd0, got[2][14]}, 15'b0);

    run_instr(6'b111111, 6'd0, -1, -1, "unk");
    seen_strobe = got[0][12] | got[0][11] | got[1][12] | got[1][11];
    check("unk_no_strobe", {14'd0, seen_strobe}, 15'b0);
    check("unk_len", 15'(got_len), 15'd2);

    run_instr(6'b101011, 6'd0, -1, 3, "sw_abort");
    check("sw_abort_memwrite", {14'd0, got[3][12]}, 15'b0);
    run_instr(6'b000010, 6'd0, -1, -1, "j_after_abort");
    check("j_after_abort_fetch_irwrite", {14'd0, got[0][13]}, 15'b1);

    run_instr(6'b001101, 6'd0, -1, -1, "ori");
`ifdef MULTICYCLE_IMM_LOGIC_EN
    check("ori_imm_alu", {12'd0, got[2][2:0]}, 15'b001);
    check("ori_wb_regwrite", {14'd0, got[3][11]}, 15'b1);
`else
    check("ori_len", 15'(got_len), 15'd2);
    run_instr(6'b001000, 6'd0, -1, -1, "addi_after_ori");
    check("addi_after_ori_irwrite", {14'd0, got[0][13]}, 15'b1);
`endif

    for (int i = 0; i < 300; i++) begin
      ro = pick_op($urandom_range(0, 10));
      rf = pick_funct($urandom_range(0, 6));
      run_instr(ro, rf, -1, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1,
                $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
